uart_baud_gen: RTL and testbench

//  Parametrised baud-rate generator for the UART. Produces single-cycle enable strobes in the clk_in domain:

---
 rtl/uart_pkg.sv | 11 +
 rtl/uart_baud_presc.sv | 70 +++++++
 rtl/uart_baud_gen.sv | 103 ++++++++++
 tb/tb_uart_baud_gen.sv | 409 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART defaults and baud divisor types.
package uart_pkg;

    localparam int unsigned UART_DIV_W  = 16;
    localparam int unsigned UART_FRAC_W = 4;
    localparam int unsigned UART_OSR    = 16;

    typedef logic [UART_DIV_W-1:0]  baud_div_t;
    typedef logic [UART_FRAC_W-1:0] baud_frac_t;

endpackage

// File: rtl/uart_baud_presc.sv
// Baud prescaler: divides clk_in into single-cycle tick_rx strobes.
// With UART_BAUD_FRAC_EN defined, a fractional accumulator stretches some periods by one cycle.
module uart_baud_presc #(
    parameter int unsigned DIV_W  = 16,
    parameter int unsigned FRAC_W = 4
) (
    input  logic              clk_in,
    input  logic              rst_n,
    input  logic              en,
    input  logic [DIV_W-1:0]  div_int,
    input  logic [FRAC_W-1:0] div_frac,
    input  logic              clr_acc,
    output logic              tick_rx
);

    logic [DIV_W-1:0] pcnt_q;
    logic [DIV_W-1:0] last;
    logic             tick_q;
    logic             carry;
    logic             wrap;

`ifdef UART_BAUD_FRAC_EN
    logic [FRAC_W-1:0] acc_q;
    logic              carry_q;

    // A freshly applied divisor must not inherit the previous divisor's carry.
    assign carry = carry_q & ~clr_acc;

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            acc_q   <= '0;
            carry_q <= 1'b0;
        end else if (!en || clr_acc) begin
            acc_q   <= '0;
            carry_q <= 1'b0;
        end else if (wrap) begin
            {carry_q, acc_q} <= {1'b0, acc_q} + {1'b0, div_frac};
        end
    end
`else
    logic unused_frac;
    assign unused_frac = ^{div_frac, clr_acc};
    assign carry       = 1'b0;
`endif

    always_comb begin
        last = (div_int > DIV_W'(1)) ? div_int - DIV_W'(1) : '0;
        last = last + DIV_W'(carry);
        wrap = (pcnt_q >= last);
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            pcnt_q <= '0;
            tick_q <= 1'b0;
        end else if (!en) begin
            pcnt_q <= '0;
            tick_q <= 1'b0;
        end else if (wrap) begin
            pcnt_q <= '0;
            tick_q <= 1'b1;
        end else begin
            pcnt_q <= pcnt_q + DIV_W'(1);
            tick_q <= 1'b0;
        end
    end

    assign tick_rx = tick_q;

endmodule

// File: rtl/uart_baud_gen.sv
// UART baud generator: tick_rx / sample_mid / tick_tx strobes with a shadowed runtime divisor.
// Optional fractional divisor enabled by defining UART_BAUD_FRAC_EN.
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int unsigned DIV_W     = UART_DIV_W,
    parameter int unsigned FRAC_W    = UART_FRAC_W,
    parameter int unsigned OSR       = UART_OSR,
    parameter int unsigned RESET_DIV = 50
) (
    input  logic                   clk_in,
    input  logic                   rst_n,
    input  logic                   en,
    input  logic                   div_wr,
    input  logic [DIV_W-1:0]       div_int,
    input  logic [FRAC_W-1:0]      div_frac,
    output logic                   div_ack,
    output logic                   div_pend,
    output logic                   tick_rx,
    output logic                   sample_mid,
    output logic                   tick_tx,
    output logic [$clog2(OSR)-1:0] osr_cnt
);

    localparam int unsigned      OSR_W   = $clog2(OSR);
    localparam logic [OSR_W-1:0] MID_PH  = OSR_W'(OSR / 2 - 1);
    localparam logic [OSR_W-1:0] LAST_PH = OSR_W'(OSR - 1);

    logic [DIV_W-1:0]  act_int_q, shd_int_q, eff_int;
    logic [FRAC_W-1:0] act_frac_q, shd_frac_q, eff_frac;
    logic              pend_q, ack_q, apply, tick;
    logic [OSR_W-1:0]  osr_q;

    // Apply points: every cycle while disabled, otherwise only the bit boundary.
    // A write landing on an apply point bypasses the shadow.
    always_comb begin
        apply    = (!en || tick_tx) && (pend_q || div_wr);
        eff_int  = act_int_q;
        eff_frac = act_frac_q;
        if (apply && div_wr) begin
            eff_int  = div_int;
            eff_frac = div_frac;
        end else if (apply) begin
            eff_int  = shd_int_q;
            eff_frac = shd_frac_q;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            act_int_q  <= DIV_W'(RESET_DIV);
            act_frac_q <= '0;
            shd_int_q  <= DIV_W'(RESET_DIV);
            shd_frac_q <= '0;
            pend_q     <= 1'b0;
            ack_q      <= 1'b0;
        end else begin
            act_int_q  <= eff_int;
            act_frac_q <= eff_frac;
            ack_q      <= apply;
            if (div_wr) begin
                shd_int_q  <= div_int;
                shd_frac_q <= div_frac;
            end
            if (apply) begin
                pend_q <= 1'b0;
            end else if (div_wr) begin
                pend_q <= 1'b1;
            end
        end
    end

    uart_baud_presc #(
        .DIV_W  (DIV_W),
        .FRAC_W (FRAC_W)
    ) u_presc (
        .clk_in   (clk_in),
        .rst_n    (rst_n),
        .en       (en),
        .div_int  (eff_int),
        .div_frac (eff_frac),
        .clr_acc  (apply),
        .tick_rx  (tick)
    );

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            osr_q <= '0;
        end else if (!en) begin
            osr_q <= '0;
        end else if (tick) begin
            osr_q <= osr_q + OSR_W'(1);
        end
    end

    assign tick_rx    = tick;
    assign sample_mid = tick && (osr_q == MID_PH);
    assign tick_tx    = tick && (osr_q == LAST_PH);
    assign osr_cnt    = osr_q;
    assign div_ack    = ack_q;
    assign div_pend   = pend_q;

endmodule

// File: tb/tb_uart_baud_gen.sv
// Self-checking bench for uart_baud_gen: directed scenarios plus randomized traffic
// checked against a period/countdown reference model.
module tb_uart_baud_gen;
    import uart_pkg::*;

    localparam int unsigned DIV_W     = UART_DIV_W;
    localparam int unsigned FRAC_W    = UART_FRAC_W;
    localparam int unsigned OSR       = UART_OSR;
    localparam int unsigned RESET_DIV = 50;
    localparam int unsigned OSR_W     = $clog2(OSR);

    logic             clk_in = 1'b0;
    logic             rst_n, en, div_wr;
    baud_div_t        div_int;
    baud_frac_t       div_frac;
    logic             div_ack, div_pend, tick_rx, sample_mid, tick_tx;
    logic [OSR_W-1:0] osr_cnt;
    logic [OSR_W+4:0] obs;

    always #5 clk_in = ~clk_in;

    uart_baud_gen #(
        .DIV_W     (DIV_W),
        .FRAC_W    (FRAC_W),
        .OSR       (OSR),
        .RESET_DIV (RESET_DIV)
    ) dut (
        .clk_in     (clk_in),
        .rst_n      (rst_n),
        .en         (en),
        .div_wr     (div_wr),
        .div_int    (div_int),
        .div_frac   (div_frac),
        .div_ack    (div_ack),
        .div_pend   (div_pend),
        .tick_rx    (tick_rx),
        .sample_mid (sample_mid),
        .tick_tx    (tick_tx),
        .osr_cnt    (osr_cnt)
    );

    assign obs = {tick_rx, sample_mid, tick_tx, div_ack, div_pend, osr_cnt};

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Reference model: active/shadow divisors, cycles remaining until the next tick, bit phase.
    int m_int, m_frac, s_int, s_frac, m_acc, m_remain, m_phase;
    bit m_pend, m_ack, m_tick;

    function automatic int base_p(int d);
        return (d <= 1) ? 1 : d;
    endfunction

    function automatic logic [OSR_W+4:0] model_vec();
        return {m_tick, m_tick && (m_phase == OSR / 2 - 1), m_tick && (m_phase == OSR - 1),
                m_ack, m_pend, OSR_W'(m_phase)};
    endfunction

    task automatic model_reset();
        m_int = RESET_DIV; m_frac = 0; s_int = RESET_DIV; s_frac = 0;
        m_acc = 0; m_remain = base_p(RESET_DIV); m_phase = 0;
        m_pend = 0; m_ack = 0; m_tick = 0;
    endtask

    task automatic model_edge();
        bit tx, ap;
        int ni, nf, sum, carry;
        tx = m_tick && (m_phase == OSR - 1);
        ap = (!en || tx) && (m_pend || div_wr);
        ni = div_wr ? int'(div_int) : s_int;
        nf = div_wr ? int'(div_frac) : s_frac;
        if (div_wr) begin
            s_int  = int'(div_int);
            s_frac = int'(div_frac);
        end
        m_ack = ap;
        if (ap) begin
            m_int  = ni;
            m_frac = nf;
        end
        m_pend = ap ? 1'b0 : (m_pend || div_wr);
        if (!en) begin
            m_phase = 0; m_tick = 0; m_acc = 0; m_remain = base_p(m_int);
        end else begin
            if (m_tick) m_phase = (m_phase + 1) % OSR;
            if (ap) begin
                m_acc    = 0;
                m_remain = base_p(m_int);
            end
            m_remain--;
            m_tick = (m_remain == 0);
            if (m_tick) begin
                carry = 0;
                if (!ap) begin
                    sum   = m_acc + m_frac;
                    m_acc = sum % (1 << FRAC_W);
`ifdef UART_BAUD_FRAC_EN
                    carry = sum >> FRAC_W;
`endif
                end
                m_remain = base_p(m_int) + carry;
            end
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        model_edge();
        cyc++;
        @(negedge clk_in);
    endtask

    task automatic test_reset();
        en = 1'b0; div_wr = 1'b0; div_int = '0; div_frac = '0;
        rst_n = 1'b0;
        model_reset();
        repeat (3) @(negedge clk_in);
        n_tests++;
        if (obs !== '0) begin
            n_fail++; $display("FAIL reset_outputs got=%b want=0", obs);
        end
        rst_n = 1'b1;
        step();
        n_tests++;
        if (obs !== model_vec()) begin
            n_fail++; $display("FAIL reset_model cyc=%0d got=%b want=%b", cyc, obs, model_vec());
        end
    endtask

    task automatic test_default_rate();
        int start, last_rx, last_tx, last_mid, n_tx;
        en = 1'b1; start = cyc; last_rx = -1; last_tx = -1; last_mid = -1; n_tx = 0;
        for (int i = 0; i < 1610; i++) begin
            step();
            n_tests++;
            if (obs !== model_vec()) begin
                n_fail++; $display("FAIL default_model cyc=%0d got=%b want=%b", cyc, obs, model_vec());
            end
            if (tick_rx) begin
                n_tests++;
                if ((cyc - (last_rx < 0 ? start : last_rx)) != 50) begin
                    n_fail++; $display("FAIL default_rx_gap cyc=%0d got=%0d want=50", cyc,
                                       cyc - (last_rx < 0 ? start : last_rx));
                end
                last_rx = cyc;
            end
            if (sample_mid) last_mid = cyc;
            if (tick_tx) begin
                n_tx++;
                n_tests++;
                if (cyc - last_mid != 400) begin
                    n_fail++; $display("FAIL default_mid_lead got=%0d want=400", cyc - last_mid);
                end
                if (last_tx >= 0) begin
                    n_tests++;
                    if (cyc - last_tx != 800) begin
                        n_fail++; $display("FAIL default_tx_gap got=%0d want=800", cyc - last_tx);
                    end
                end
                last_tx = cyc;
            end
        end
        n_tests++;
        if (n_tx != 2) begin
            n_fail++; $display("FAIL default_tx_count got=%0d want=2", n_tx);
        end
    endtask

    task automatic test_div_update();
        int guard, tx_cyc, last_rx, n_ack;
        guard = 0;
        while (osr_cnt != OSR_W'(3) && guard < 2000) begin
            step(); guard++;
        end
        n_tests++;
        if (guard >= 2000) begin
            n_fail++; $display("FAIL update_wait_phase got=timeout want=osr_cnt 3");
        end
        repeat (5) step();
        div_int = 10; div_wr = 1'b1;
        step();
        div_wr = 1'b0;
        n_tests++;
        if (div_pend !== 1'b1) begin
            n_fail++; $display("FAIL update_pend_set got=%b want=1", div_pend);
        end
        tx_cyc = -1; last_rx = -1; n_ack = 0;
        for (int i = 0; i < 1200; i++) begin
            step();
            n_tests++;
            if (obs !== model_vec()) begin
                n_fail++; $display("FAIL update_model cyc=%0d got=%b want=%b", cyc, obs, model_vec());
            end
            if (div_ack) n_ack++;
            if (tx_cyc < 0) begin
                n_tests++;
                if (div_pend !== 1'b1) begin
                    n_fail++; $display("FAIL update_pend_hold cyc=%0d got=%b want=1", cyc, div_pend);
                end
                if (tick_tx) begin
                    tx_cyc = cyc; last_rx = cyc;
                end
            end else begin
                if (cyc == tx_cyc + 1) begin
                    n_tests++;
                    if (div_ack !== 1'b1 || div_pend !== 1'b0) begin
                        n_fail++; $display("FAIL update_ack got=%b%b want=10", div_ack, div_pend);
                    end
                end
                if (tick_rx) begin
                    n_tests++;
                    if (cyc - last_rx != 10) begin
                        n_fail++; $display("FAIL update_rx_gap got=%0d want=10", cyc - last_rx);
                    end
                    last_rx = cyc;
                end
            end
        end
        n_tests++;
        if (tx_cyc < 0 || n_ack != 1) begin
            n_fail++; $display("FAIL update_ack_count got=%0d want=1 (tx_cyc=%0d)", n_ack, tx_cyc);
        end
    endtask

    task automatic test_back_to_back();
        int guard, tx_cyc, last_rx, n_ack;
        guard = 0;
        while (osr_cnt != OSR_W'(4) && guard < 500) begin
            step(); guard++;
        end
        div_int = 7; div_wr = 1'b1;
        step();
        div_wr = 1'b0;
        repeat (3) step();
        div_int = 5; div_wr = 1'b1;
        step();
        div_wr = 1'b0;
        tx_cyc = -1; last_rx = -1; n_ack = 0;
        for (int i = 0; i < 400; i++) begin
            step();
            n_tests++;
            if (obs !== model_vec()) begin
                n_fail++; $display("FAIL b2b_model cyc=%0d got=%b want=%b", cyc, obs, model_vec());
            end
            if (div_ack) n_ack++;
            if (tx_cyc < 0 && tick_tx) begin
                tx_cyc = cyc; last_rx = cyc;
            end else if (tx_cyc >= 0 && tick_rx) begin
                n_tests++;
                if (cyc - last_rx != 5) begin
                    n_fail++; $display("FAIL b2b_rx_gap got=%0d want=5", cyc - last_rx);
                end
                last_rx = cyc;
            end
        end
        n_tests++;
        if (tx_cyc < 0 || n_ack != 1) begin
            n_fail++; $display("FAIL b2b_ack_count got=%0d want=1 (tx_cyc=%0d)", n_ack, tx_cyc);
        end
    endtask

    task automatic test_min_div();
        int n_tx;
        for (int d = 1; d >= 0; d--) begin
            en = 1'b0; div_int = DIV_W'(d); div_wr = 1'b1;
            step();
            div_wr = 1'b0; en = 1'b1; n_tx = 0;
            for (int i = 0; i < 48; i++) begin
                step();
                n_tests++;
                if (tick_rx !== 1'b1 || obs !== model_vec()) begin
                    n_fail++; $display("FAIL min_div%0d cyc=%0d got=%b want=%b", d, cyc, obs, model_vec());
                end
                if (tick_tx) n_tx++;
            end
            n_tests++;
            if (n_tx != 3) begin
                n_fail++; $display("FAIL min_div%0d_tx_count got=%0d want=3", d, n_tx);
            end
        end
    endtask

`ifdef UART_BAUD_FRAC_EN
    task automatic test_frac();
        int ticks[$];
        en = 1'b0; div_int = 3; div_frac = 8; div_wr = 1'b1;
        step();
        div_wr = 1'b0; div_frac = '0; en = 1'b1;
        for (int i = 0; i < 100; i++) begin
            step();
            n_tests++;
            if (obs !== model_vec()) begin
                n_fail++; $display("FAIL frac_model cyc=%0d got=%b want=%b", cyc, obs, model_vec());
            end
            if (tick_rx) ticks.push_back(cyc);
        end
        n_tests++;
        if (ticks.size() < 17 || ticks[16] - ticks[0] != 56) begin
            n_fail++; $display("FAIL frac_16_ticks got=%0d ticks want=56 cycles", ticks.size());
        end
        en = 1'b0; div_wr = 1'b1; div_int = 3; div_frac = '0;
        step();
        div_wr = 1'b0;
    endtask
`endif

    task automatic test_en_drop();
        int guard, start;
        en = 1'b0; div_int = 7; div_wr = 1'b1;
        step();
        div_wr = 1'b0; en = 1'b1; guard = 0;
        while (osr_cnt != OSR_W'(5) && guard < 500) begin
            step(); guard++;
        end
        repeat (3) step();
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            n_tests++;
            if ({tick_rx, sample_mid, tick_tx} !== 3'b000 || osr_cnt !== '0 || obs !== model_vec()) begin
                n_fail++; $display("FAIL en_drop_idle cyc=%0d got=%b want=%b", cyc, obs, model_vec());
            end
        end
        en = 1'b1; start = cyc; guard = 0;
        while (!tick_rx && guard < 50) begin
            step(); guard++;
        end
        n_tests++;
        if (!tick_rx || cyc - start != 7) begin
            n_fail++; $display("FAIL en_drop_first_tick got=%0d want=7", cyc - start);
        end
    endtask

    task automatic test_reset_pending();
        int guard, start;
        repeat (20) step();
        div_int = 12; div_wr = 1'b1;
        step();
        div_wr = 1'b0;
        n_tests++;
        if (div_pend !== 1'b1) begin
            n_fail++; $display("FAIL rstpend_pend got=%b want=1", div_pend);
        end
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        n_tests++;
        if (obs !== '0) begin
            n_fail++; $display("FAIL rstpend_async got=%b want=0", obs);
        end
        @(negedge clk_in);
        rst_n = 1'b1; start = cyc; guard = 0;
        while (!tick_rx && guard < 100) begin
            step(); guard++;
        end
        n_tests++;
        if (!tick_rx || cyc - start != RESET_DIV) begin
            n_fail++; $display("FAIL rstpend_first_tick got=%0d want=%0d", cyc - start, RESET_DIV);
        end
    endtask

    task automatic test_random();
        int off_left;
        off_left = 0;
        for (int i = 0; i < 4000; i++) begin
            if (off_left > 0) begin
                off_left--;
                en = 1'b0;
            end else begin
                en = 1'b1;
                if ($urandom_range(0, 299) == 0) off_left = $urandom_range(1, 4);
            end
            div_wr = ($urandom_range(0, 39) == 0);
            div_int = DIV_W'($urandom_range(0, 9));
            div_frac = FRAC_W'($urandom);
            step();
            n_tests++;
            if (obs !== model_vec()) begin
                n_fail++; $display("FAIL random_model cyc=%0d got=%b want=%b", cyc, obs, model_vec());
            end
        end
        div_wr = 1'b0;
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_default_rate();
        test_div_update();
        test_back_to_back();
        test_min_div();
`ifdef UART_BAUD_FRAC_EN
        test_frac();
`endif
        test_en_drop();
        test_reset_pending();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
